// File: rtl/tt_ctrl_pkg.sv
// Shared types and default constants for the project-select control decoder.
package tt_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF      = 10;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        COUNT  = 2'd1,
        ACTIVE = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/tt_ctrl_sync.sv
// Multi-flop synchroniser for one asynchronous pad input, synchronous reset to 0.
module tt_ctrl_sync
    import tt_ctrl_pkg::*;
#(
    parameter int unsigned STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the pad value through the synchroniser chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/tt_ctrl_decoder.sv
// Project-select decoder: synchronises the three ctrl pads, counts sel_inc
// edges, and locks the count into sel_addr when ena is raised.
// Optional build macro: TT_CTRL_DEGLITCH_EN adds a stability filter on s_inc.
//
//   state  | meaning
//   CLEAR  | counter and overflow held at 0, project disabled
//   COUNT  | sel_inc edges advance the counter, project disabled
//   ACTIVE | sel_addr locked, project enabled, edges discarded
module tt_ctrl_decoder
    import tt_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W          = ADDR_W_DEF,
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEGLITCH_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ctrl_sel_rst_n,
    input  logic              ctrl_sel_inc,
    input  logic              ctrl_ena,
    output logic [ADDR_W-1:0] sel_addr,
    output logic              sel_ena,
    output logic [ADDR_W-1:0] sel_cnt,
    output logic              sel_ovf
);

    if (SYNC_STAGES < 2 || DEGLITCH_CYCLES < 1) begin : g_param_check
        $error("tt_ctrl_decoder: SYNC_STAGES must be >= 2 and DEGLITCH_CYCLES >= 1");
    end

    logic s_rst_n;
    logic s_inc;
    logic s_ena;
    logic inc_filt;
    logic inc_dly_q;
    logic inc_edge;

    ctrl_state_e       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ovf_q, ovf_d;

    tt_ctrl_sync #(.STAGES(SYNC_STAGES)) u_sync_rst (
        .clk(clk), .rst_n(rst_n), .d_i(ctrl_sel_rst_n), .q_o(s_rst_n)
    );
    tt_ctrl_sync #(.STAGES(SYNC_STAGES)) u_sync_inc (
        .clk(clk), .rst_n(rst_n), .d_i(ctrl_sel_inc), .q_o(s_inc)
    );
    tt_ctrl_sync #(.STAGES(SYNC_STAGES)) u_sync_ena (
        .clk(clk), .rst_n(rst_n), .d_i(ctrl_ena), .q_o(s_ena)
    );

`ifdef TT_CTRL_DEGLITCH_EN
    localparam int unsigned DG_W = (DEGLITCH_CYCLES > 1) ? $clog2(DEGLITCH_CYCLES) : 1;

    logic [DG_W-1:0] dg_cnt_q, dg_cnt_d;
    logic            dg_val_q, dg_val_d;

    // Accept a new s_inc level only after it has differed from the filtered
    // level for DEGLITCH_CYCLES consecutive samples.
    always_comb begin
        dg_cnt_d = '0;
        dg_val_d = dg_val_q;
        if (s_inc != dg_val_q) begin
            if (dg_cnt_q == DG_W'(DEGLITCH_CYCLES - 1)) begin
                dg_val_d = s_inc;
            end else begin
                dg_cnt_d = dg_cnt_q + DG_W'(1);
            end
        end
    end

    // Deglitch filter state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dg_cnt_q <= '0;
            dg_val_q <= 1'b0;
        end else begin
            dg_cnt_q <= dg_cnt_d;
            dg_val_q <= dg_val_d;
        end
    end

    assign inc_filt = dg_val_q;
`else
    assign inc_filt = s_inc;
`endif

    assign inc_edge = inc_filt & ~inc_dly_q;

    // Next state, counter, lock and overflow; clear dominates any increment.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        ovf_d   = ovf_q;
        if (!s_rst_n) begin
            state_d = CLEAR;
        end else begin
            case (state_q)
                CLEAR:   state_d = COUNT;
                COUNT: begin
                    if (s_ena) begin
                        state_d = ACTIVE;
                        addr_d  = cnt_q;
                    end
                end
                ACTIVE: begin
                    if (!s_ena) state_d = COUNT;
                end
                default: state_d = CLEAR;
            endcase
        end
        if (!s_rst_n || state_q == CLEAR) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (state_q == COUNT && !s_ena && inc_edge) begin
            // Locking on this edge takes the pre-increment value and drops the edge.
            cnt_d = cnt_q + ADDR_W'(1);
            if (&cnt_q) ovf_d = 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            cnt_q     <= '0;
            addr_q    <= '0;
            ovf_q     <= 1'b0;
            inc_dly_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            ovf_q     <= ovf_d;
            inc_dly_q <= inc_filt;
        end
    end

    assign sel_addr = addr_q;
    assign sel_cnt  = cnt_q;
    assign sel_ovf  = ovf_q;
    assign sel_ena  = (state_q == ACTIVE);

endmodule

// File: doc/tt_ctrl_decoder.md
TT_CTRL_DECODER -- requirements
Module: tt_ctrl_decoder

Interface
REQ-001 Parameter ADDR_W, default 10, width of the project-select address and counter.
REQ-002 Parameter SYNC_STAGES, default 2, number of synchroniser flops per ctrl pad input (minimum 2).
REQ-003 Parameter DEGLITCH_CYCLES, default 3, number of consecutive stable cycles required on sel_inc when the deglitch feature is compiled in.
REQ-004 clk  input  1  Single block clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  Reset; synchronous and active-low.
REQ-006 ctrl_sel_rst_n  input  1  Raw pad input (ctrl[2], asynchronous); low clears the select counter.
REQ-007 ctrl_sel_inc  input  1  Raw pad input (ctrl[1], asynchronous); each rising edge increments the select counter.
REQ-008 ctrl_ena  input  1  Raw pad input (ctrl[0], asynchronous); high locks the address and enables the selected project.
REQ-009 sel_addr  output  ADDR_W  Locked project address, valid while sel_ena is high.
REQ-010 sel_ena  output  1  Selected project enable.
REQ-011 sel_cnt  output  ADDR_W  Live counter value, for debug readback.
REQ-012 sel_ovf  output  1  Sticky flag: the counter wrapped since the last clear.

Function
REQ-013 Each ctrl input SHALL pass through a SYNC_STAGES flop synchroniser; all logic SHALL use only synchronised values (s_rst_n, s_inc, s_ena).
REQ-014 Increment detection SHALL be a rising edge of s_inc, detected against a one-cycle-delayed copy.
REQ-015 FSM states: CLEAR, COUNT, ACTIVE.
- CLEAR: counter=0, sel_ovf=0, sel_ena=0.
- COUNT: counting; sel_ena=0.
- ACTIVE: address locked; sel_ena=1.
REQ-016 Transitions, with priority top to bottom:
- s_rst_n=0 -> CLEAR from any state.
- CLEAR and s_rst_n=1 -> COUNT.
- COUNT and s_ena=1 -> ACTIVE; sel_addr<=counter on that same edge.
- ACTIVE and s_ena=0 -> COUNT.
REQ-017 In COUNT, each detected edge SHALL increment the counter by 1 modulo 2^ADDR_W.
REQ-018 An increment from all-ones SHALL wrap the counter to 0 and set sel_ovf=1; sel_ovf stays set until the FSM passes through CLEAR.
REQ-019 An edge detected in CLEAR or ACTIVE SHALL be discarded.
- sel_rst_n low together with an increment: the clear wins.
- ena rising together with an increment: the address locks the pre-increment value and the increment is dropped.
REQ-020 Latency with SYNC_STAGES=2 and deglitch out: a pad edge sampled at clock edge k SHALL update sel_cnt at edge k+2; sel_ena SHALL rise at edge k+2 after ctrl_ena is sampled high.
REQ-021 sel_addr SHALL hold its last locked value outside ACTIVE.

Reset
REQ-022 With rst_n=0 at a clock edge, the block SHALL reset as follows:
- all synchroniser flops, the delayed copy and the deglitch state to 0;
- counter, sel_addr and sel_ovf to 0, and sel_ena to 0;
- FSM to CLEAR.
REQ-023 Reset asserted mid-count or during ACTIVE SHALL drop sel_ena at the same edge; there is no asynchronous path.

Configuration
REQ-024 The macro TT_CTRL_DEGLITCH_EN controls a deglitch filter on s_inc:
- Defined: s_inc SHALL feed the edge detector only after holding the same value for DEGLITCH_CYCLES consecutive cycles. Pulses shorter than that SHALL be ignored, and latency grows by DEGLITCH_CYCLES.
- Undefined: s_inc SHALL feed the edge detector directly.

Structure
REQ-025 Package tt_ctrl_pkg SHALL hold:
- the FSM state enum (CLEAR, COUNT, ACTIVE);
- the default ADDR_W constant;
- the default SYNC_STAGES constant.
REQ-026 Sub-module tt_ctrl_sync (parameterised depth, synchronous reset to 0) SHALL be instantiated once per ctrl input.

Verification
REQ-027 Clear and count: hold ctrl_sel_rst_n low for 4 cycles, release, then give 5 inc pulses of 4 cycles each, then raise ctrl_ena.
- Expected: sel_cnt=5, sel_addr=5, sel_ena=1 at 2 cycles after ena is sampled.
REQ-028 Wrap: with ADDR_W=3, give 9 pulses.
- Expected: sel_cnt=1 and sel_ovf=1; after a sel_rst_n low pulse, sel_ovf=0 and sel_cnt=0.
REQ-029 Lock: with sel_addr=5 in ACTIVE, give 3 inc pulses, then drop ena.
- Expected: sel_addr stays 5, sel_cnt stays 5, sel_ena=0 two cycles after the drop.
REQ-030 Simultaneity: sel_rst_n falls in the same cycle as an inc edge.
- Expected: sel_cnt=0, with no transient value of 1.
REQ-031 Reset mid-operation: assert rst_n=0 in ACTIVE with sel_addr=7.
- Expected: sel_ena, sel_addr and sel_cnt are 0 at the next edge.
REQ-032 Deglitch (TT_CTRL_DEGLITCH_EN defined): a 2-cycle inc pulse leaves sel_cnt unchanged; a 4-cycle pulse increments it by 1.
